// File: rtl/sysu_sram_ctrl.sv
// Request/ack sequencer for the 4x4 SRAM: orders address, data and active-low strobes, and handles a 4-word clear.
// Ack is +4 cycles (write), +5 (read) or +13 (clear); req/clr arriving while busy are dropped, not queued.
module sysu_sram_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [3:0] wdata,
    input  logic       clr,
    output logic       busy,
    output logic       ack,
    output logic [3:0] rdata,
    output logic       A1,
    output logic       A0,
    output logic       I3,
    output logic       I2,
    output logic       I1,
    output logic       I0,
    output logic       en,
    output logic       WR,
    output logic       RD,
    input  logic       D3,
    input  logic       D2,
    input  logic       D1,
    input  logic       D0
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        RELEASE = 3'd3,
        DRIVE   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t     state;
    state_t     next_state;
    logic       op_we;
    logic       op_clr;
    logic [1:0] addr_q;
    logic [3:0] data_q;
    logic       en_nx;
    logic       wr_nx;
    logic       rd_nx;
    logic       busy_nx;
    logic       ack_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (clr || req) next_state = SETUP;
            SETUP:   next_state = STROBE;
            STROBE:  next_state = RELEASE;
            RELEASE: begin
                if (!op_we)                        next_state = DRIVE;
                else if (op_clr && addr_q != 2'd3) next_state = SETUP;
                else                               next_state = DONE;
            end
            DRIVE:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes are decoded from the state being entered so they leave flops glitch-free.
    always_comb begin
        en_nx   = !(next_state == STROBE || next_state == DRIVE);
        wr_nx   = !(next_state == STROBE && op_we);
        rd_nx   = !(next_state == STROBE && !op_we);
        busy_nx = (next_state != IDLE);
        ack_nx  = (next_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_we  <= 1'b0;
            op_clr <= 1'b0;
            addr_q <= 2'd0;
            data_q <= 4'd0;
            rdata  <= 4'd0;
            en     <= 1'b1;
            WR     <= 1'b1;
            RD     <= 1'b1;
            busy   <= 1'b0;
            ack    <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (clr) begin
                    op_we  <= 1'b1;
                    op_clr <= 1'b1;
                    addr_q <= 2'd0;
                    data_q <= 4'd0;
                end else if (req) begin
                    op_we  <= we;
                    op_clr <= 1'b0;
                    addr_q <= addr;
                    data_q <= wdata;
                end
            end
            // Clear walks 0..3 and stops; the counter never wraps back to 0.
            if (state == RELEASE && op_clr && addr_q != 2'd3) begin
                addr_q <= addr_q + 2'd1;
            end
            // D is only valid after the second falling enable in DRIVE.
            if (state == DRIVE) begin
                rdata <= {D3, D2, D1, D0};
            end
            en   <= en_nx;
            WR   <= wr_nx;
            RD   <= rd_nx;
            busy <= busy_nx;
            ack  <= ack_nx;
        end
    end

    assign A1 = addr_q[1];
    assign A0 = addr_q[0];
    assign I3 = data_q[3];
    assign I2 = data_q[2];
    assign I1 = data_q[1];
    assign I0 = data_q[0];

endmodule

// File: tb/tb_sysu_sram_ctrl.sv
// Bench for sysu_sram_ctrl: SRAM array model, protocol monitor, vector table, corner sequences and random ops.
module tb_sysu_sram_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       we = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [3:0] wdata = 4'd0;
    logic       clr = 1'b0;
    logic       busy, ack;
    logic [3:0] rdata;
    logic       A1, A0, I3, I2, I1, I0, en, WR, RD;
    logic       D3, D2, D1, D0;

    sysu_sram_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .clr(clr),
        .busy(busy), .ack(ack), .rdata(rdata),
        .A1(A1), .A0(A0), .I3(I3), .I2(I2), .I1(I1), .I0(I0),
        .en(en), .WR(WR), .RD(RD),
        .D3(D3), .D2(D2), .D1(D1), .D0(D0)
    );

    always #5 clk = ~clk;

    // SRAM array: write on falling WR, latch on falling RD, refresh D only on falling en.
    logic [3:0] mem [4];
    logic [3:0] latch_q = 4'd0;
    logic [3:0] dout = 4'd0;
    logic       en_p = 1'b1, wr_p = 1'b1, rd_p = 1'b1;

    always @(negedge clk) begin
        if (!en && en_p) dout = latch_q;
        if (!en && !WR && wr_p) mem[{A1, A0}] = {I3, I2, I1, I0};
        if (!en && !RD && rd_p) latch_q = mem[{A1, A0}];
        en_p = en;
        wr_p = WR;
        rd_p = RD;
    end

    assign {D3, D2, D1, D0} = dout;

    // Protocol monitor
    int         proto_err = 0;
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         ack_cnt = 0;
    logic       mwr_p = 1'b1, mrd_p = 1'b1;
    logic [1:0] wa_q [$];
    logic [3:0] wi_q [$];

    always @(negedge clk) begin
        if (!WR && !RD) proto_err++;
        if ((!WR || !RD) && en) proto_err++;
        if (!WR && mwr_p) begin
            wr_cnt++;
            wa_q.push_back({A1, A0});
            wi_q.push_back({I3, I2, I1, I0});
        end
        if (!RD && mrd_p) rd_cnt++;
        if (ack) ack_cnt++;
        mwr_p = WR;
        mrd_p = RD;
    end

    // Reference model: array contents and the last word read
    logic [3:0] mem_ref [4];
    logic [3:0] rdata_ref = 4'd0;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic run_op(input bit c, input bit w, input logic [1:0] a, input logic [3:0] d,
                          input bit both, input int exp_lat, input logic [3:0] exp_rd,
                          input int exp_wr);
        int lat;
        int wr0, rd0, pe0;
        bit got;
        wr0 = wr_cnt; rd0 = rd_cnt; pe0 = proto_err;
        wa_q.delete();
        wi_q.delete();
        clr = c; req = !c || both; we = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
        clr = 0; req = 0;
        we = 1'($urandom); addr = 2'($urandom); wdata = 4'($urandom);
        lat = 0; got = 0;
        for (int n = 1; n <= 30 && !got; n++) begin
            @(negedge clk);
            if (n == 1) chk("busy_cycle1", busy, 1);
            if (ack) begin
                got = 1;
                lat = n;
            end
        end
        chk("ack_latency", lat, exp_lat);
        chk("rdata", rdata, exp_rd);
        chk("wr_pulses", wr_cnt - wr0, exp_wr);
        chk("rd_pulses", rd_cnt - rd0, (c || w) ? 0 : 1);
        chk("strobe_protocol", proto_err - pe0, 0);
        for (int i = 0; i < wa_q.size(); i++) begin
            chk("wr_addr", wa_q[i], c ? i : a);
            chk("wr_data", wi_q[i], c ? 0 : d);
        end
        if (c) begin
            for (int i = 0; i < 4; i++) mem_ref[i] = 4'd0;
        end else if (w) begin
            mem_ref[a] = d;
        end else begin
            rdata_ref = mem_ref[a];
        end
        @(negedge clk);
        chk("idle_after_ack", {busy, ack}, 0);
    endtask

    task automatic model_op(input bit c, input bit w, input logic [1:0] a, input logic [3:0] d,
                            input bit both);
        int         exp_lat;
        int         exp_wr;
        logic [3:0] exp_rd;
        exp_lat = c ? 13 : (w ? 4 : 5);
        exp_wr  = c ? 4 : (w ? 1 : 0);
        exp_rd  = (c || w) ? rdata_ref : mem_ref[a];
        run_op(c, w, a, d, both, exp_lat, exp_rd, exp_wr);
    endtask

    task automatic cadence(input bit w, input int exp_gap);
        int times [2];
        int n_ack;
        times[0] = 0; times[1] = 0; n_ack = 0;
        req = 1; we = w; addr = 2'd2; wdata = 4'h6;
        for (int n = 0; n < 40 && n_ack < 2; n++) begin
            @(negedge clk);
            if (ack) begin
                times[n_ack] = n;
                n_ack++;
            end
        end
        req = 0;
        chk(w ? "wr_cadence" : "rd_cadence", times[1] - times[0], exp_gap);
        if (w) mem_ref[2] = 4'h6;
        else   rdata_ref = mem_ref[2];
        chk("cadence_rdata", rdata, rdata_ref);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        bit         c;
        bit         w;
        logic [1:0] a;
        logic [3:0] d;
        int         lat;
        logic [3:0] rd;
        int         wrp;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int ack0, wr0, r;
        tbl[0]  = '{0, 1, 2'd2, 4'hA, 4,  4'h0, 1};
        tbl[1]  = '{0, 0, 2'd2, 4'h0, 5,  4'hA, 0};
        tbl[2]  = '{0, 1, 2'd0, 4'h5, 4,  4'hA, 1};
        tbl[3]  = '{0, 1, 2'd1, 4'h3, 4,  4'hA, 1};
        tbl[4]  = '{0, 1, 2'd2, 4'hC, 4,  4'hA, 1};
        tbl[5]  = '{0, 1, 2'd3, 4'hF, 4,  4'hA, 1};
        tbl[6]  = '{0, 0, 2'd0, 4'h0, 5,  4'h5, 0};
        tbl[7]  = '{0, 0, 2'd1, 4'h0, 5,  4'h3, 0};
        tbl[8]  = '{0, 0, 2'd2, 4'h0, 5,  4'hC, 0};
        tbl[9]  = '{0, 0, 2'd3, 4'h0, 5,  4'hF, 0};
        tbl[10] = '{1, 1, 2'd0, 4'h0, 13, 4'hF, 4};
        tbl[11] = '{0, 0, 2'd0, 4'h0, 5,  4'h0, 0};
        tbl[12] = '{0, 0, 2'd1, 4'h0, 5,  4'h0, 0};
        tbl[13] = '{0, 0, 2'd2, 4'h0, 5,  4'h0, 0};
        tbl[14] = '{0, 0, 2'd3, 4'h0, 5,  4'h0, 0};
        for (int i = 0; i < 4; i++) begin
            mem[i] = 4'd0;
            mem_ref[i] = 4'd0;
        end

        // Reset held two cycles
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("rst_strobes", {en, WR, RD}, 3'b111);
        chk("rst_addr", {A1, A0}, 0);
        chk("rst_wdata", {I3, I2, I1, I0}, 0);
        chk("rst_busy_ack", {busy, ack}, 0);
        chk("rst_rdata", rdata, 0);

        foreach (tbl[i]) run_op(tbl[i].c, tbl[i].w, tbl[i].a, tbl[i].d, 1'b0,
                                tbl[i].lat, tbl[i].rd, tbl[i].wrp);

        // req pulsed while a write is in flight is dropped
        ack0 = ack_cnt; wr0 = wr_cnt;
        req = 1; we = 1; addr = 2'd1; wdata = 4'h9;
        @(posedge clk);
        #1 req = 0;
        @(posedge clk);
        #1;
        req = 1; we = 1; addr = 2'd3; wdata = 4'h6;
        @(posedge clk);
        #1 req = 0;
        repeat (12) @(negedge clk);
        chk("busy_req_acks", ack_cnt - ack0, 1);
        chk("busy_req_writes", wr_cnt - wr0, 1);
        mem_ref[1] = 4'h9;
        model_op(0, 0, 2'd3, 4'h0, 0);
        model_op(0, 0, 2'd1, 4'h0, 0);

        // clr wins over a simultaneous req
        model_op(1, 1, 2'd2, 4'h7, 1);
        model_op(0, 0, 2'd1, 4'h0, 0);

        // Reset during the STROBE cycle of a read
        model_op(0, 1, 2'd1, 4'hB, 0);
        model_op(0, 0, 2'd0, 4'h0, 0);
        model_op(0, 1, 2'd0, 4'h4, 0);
        model_op(0, 0, 2'd0, 4'h0, 0);
        ack0 = ack_cnt;
        req = 1; we = 0; addr = 2'd1;
        @(posedge clk);
        #1 req = 0;
        @(posedge clk);
        #1;
        chk("strobe_rd_low", {en, RD}, 0);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        chk("rst_mid_strobes", {en, WR, RD}, 3'b111);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rdata", rdata, 0);
        repeat (3) @(negedge clk);
        chk("rst_mid_no_ack", ack_cnt - ack0, 0);
        rdata_ref = 4'd0;
        model_op(0, 0, 2'd1, 4'h0, 0);

        cadence(1, 5);
        cadence(0, 6);

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) model_op(1, 1, 2'($urandom), 4'($urandom), 1'($urandom));
            else if (r < 5) model_op(0, 1, 2'($urandom), 4'($urandom), 0);
            else model_op(0, 0, 2'($urandom), 4'($urandom), 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
